// File: rtl/pix_mem_arbiter.sv
// Pixel memory arbiter: MEM stage (priority) vs display burst reader, with bounded-wait anti-starvation.
// Latency: memory port driven in the grant cycle; read data returns one cycle later to its owner.
// Backpressure: CPU sees cpu_stall until granted; burst requester holds dsp_req until dsp_grant.
module pix_mem_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 10,
    parameter int CPU_MAX_WAIT = 4,
    parameter int DSP_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dsp_req,
    input  logic [ADDR_W-1:0] dsp_addr,
    input  logic [LEN_W-1:0]  dsp_len,
    output logic              dsp_grant,
    output logic [DATA_W-1:0] dsp_rdata,
    output logic              dsp_rvalid,
    output logic              dsp_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW_W = $clog2(CPU_MAX_WAIT + 1);
    localparam int DW_W = $clog2(DSP_MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE0 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW_W-1:0]   cpu_wait;
    logic [DW_W-1:0]   dsp_wait;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              rd_vld;
    logic              rd_dsp;
    logic              rd_last;
    logic              cpu_gnt;
    logic              beat;
    logic              dsp_take;

    always_comb begin
        state_nxt = state;
        cpu_gnt   = 1'b0;
        dsp_grant = 1'b0;
        beat      = 1'b0;
        dsp_take  = dsp_req && (!cpu_req || dsp_wait == DW_W'(DSP_MAX_WAIT));
        case (state)
            IDLE: begin
                if (dsp_take) begin
                    dsp_grant = 1'b1;
                    state_nxt = (dsp_len != '0) ? BURST : DONE0;
                end else begin
                    cpu_gnt = cpu_req;
                end
            end
            BURST: begin
                // A CPU that has waited its full budget steals one slot; the burst simply pauses.
                if (cpu_req && cpu_wait == CW_W'(CPU_MAX_WAIT)) begin
                    cpu_gnt = 1'b1;
                end else begin
                    beat = 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DONE0: begin
                cpu_gnt   = cpu_req;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = cpu_gnt | beat;
        mem_we    = cpu_gnt & cpu_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            if (cpu_we) begin
                mem_wdata = cpu_wdata;
            end
        end else if (beat) begin
            mem_addr = cur_addr;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rvalid = rd_vld & ~rd_dsp;
    assign dsp_rvalid = rd_vld & rd_dsp;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dsp_rdata  = dsp_rvalid ? mem_rdata : '0;
    assign dsp_done   = (dsp_rvalid & rd_last) | (state == DONE0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cpu_wait  <= '0;
            dsp_wait  <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            rd_vld    <= 1'b0;
            rd_dsp    <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_vld  <= (cpu_gnt & ~cpu_we) | beat;
            rd_dsp  <= beat;
            rd_last <= beat && remaining == LEN_W'(1);

            if (dsp_grant) begin
                cur_addr  <= dsp_addr;
                remaining <= dsp_len;
            end else if (beat) begin
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end

            if (!cpu_req || cpu_gnt) begin
                cpu_wait <= '0;
            end else if (cpu_wait != CW_W'(CPU_MAX_WAIT)) begin
                cpu_wait <= cpu_wait + 1'b1;
            end

            // Only refusals while IDLE count against the burst requester.
            if (!dsp_req || dsp_grant) begin
                dsp_wait <= '0;
            end else if (state == IDLE && dsp_wait != DW_W'(DSP_MAX_WAIT)) begin
                dsp_wait <= dsp_wait + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pix_mem_arbiter.sv
// Directed bench for pix_mem_arbiter with a 1-cycle-latency memory model.
// Unwritten locations read back as 0xA0000000 | addr.
module tb_pix_mem_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              dsp_req;
    logic [ADDR_W-1:0] dsp_addr;
    logic [LEN_W-1:0]  dsp_len;
    logic              dsp_grant;
    logic [DATA_W-1:0] dsp_rdata;
    logic              dsp_rvalid;
    logic              dsp_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem_arr [0:(1<<ADDR_W)-1];
    logic              written [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_arr[mem_addr] <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else if (written[mem_addr] === 1'b1) begin
                mem_rdata <= mem_arr[mem_addr];
            end else begin
                mem_rdata <= 32'hA000_0000 | {15'd0, mem_addr};
            end
        end
    end

    pix_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_len(dsp_len),
        .dsp_grant(dsp_grant), .dsp_rdata(dsp_rdata), .dsp_rvalid(dsp_rvalid), .dsp_done(dsp_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dsp_req   = 1'b0;
        dsp_addr  = '0;
        dsp_len   = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({cpu_stall, cpu_rvalid, dsp_grant, dsp_rvalid, dsp_done, mem_en, mem_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {cpu_stall, cpu_rvalid, dsp_grant, dsp_rvalid, dsp_done, mem_en, mem_we});
        end
        checks++;
        if ({cpu_rdata, dsp_rdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: cpu_rdata=%h dsp_rdata=%h mem_addr=%h mem_wdata=%h expected all 0",
                     cpu_rdata, dsp_rdata, mem_addr, mem_wdata);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cpu_only;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00010; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({cpu_stall, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b011, 17'h00010, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL cpu_write: stall=%b en=%b we=%b addr=%h wdata=%h expected 0 1 1 00010 deadbeef",
                     cpu_stall, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_stall, mem_en, mem_we, mem_addr} !== {3'b010, 17'h00010}) begin
            errors++;
            $display("FAIL cpu_read_issue: stall=%b en=%b we=%b addr=%h expected 0 1 0 00010",
                     cpu_stall, mem_en, mem_we, mem_addr);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, dsp_rvalid, cpu_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL cpu_read_data: cpu_rvalid=%b dsp_rvalid=%b rdata=%h expected 1 0 deadbeef",
                     cpu_rvalid, dsp_rvalid, cpu_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_rvalid_pulse: got %b expected 0", cpu_rvalid);
        end
        tick();
    endtask

    task automatic test_burst_wrap;
        logic [ADDR_W-1:0] exp_addr [4];
        exp_addr = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
        dsp_req = 1'b1; dsp_addr = 17'h1FFFE; dsp_len = 10'd4;
        @(negedge clk);
        checks++;
        if ({dsp_grant, mem_en} !== 2'b10) begin
            errors++;
            $display("FAIL burst_grant: grant=%b mem_en=%b expected 1 0", dsp_grant, mem_en);
        end
        tick();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_en, dsp_rvalid, dsp_done, dsp_grant} !== {i < 4, i >= 1 && i <= 4, i == 4, 1'b0}) begin
                errors++;
                $display("FAIL burst_cycle%0d: en/rvalid/done/grant=%b expected %b", i,
                         {mem_en, dsp_rvalid, dsp_done, dsp_grant},
                         {i < 4, i >= 1 && i <= 4, i == 4, 1'b0});
            end
            if (i < 4) begin
                checks++;
                if (mem_addr !== exp_addr[i]) begin
                    errors++;
                    $display("FAIL burst_addr%0d: got %h expected %h", i, mem_addr, exp_addr[i]);
                end
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (dsp_rdata !== (32'hA000_0000 | {15'd0, exp_addr[i-1]})) begin
                    errors++;
                    $display("FAIL burst_data%0d: got %h expected %h", i, dsp_rdata,
                             32'hA000_0000 | {15'd0, exp_addr[i-1]});
                end
            end
            tick();
        end
    endtask

    task automatic test_contention;
        int refused = 0;
        int stalls = 0;
        int rv = 0;
        int dn = 0;
        logic got = 1'b0;
        logic stall_at_grant = 1'b0;
        logic en_at_grant = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00020; cpu_wdata = 32'h1234_5678;
        dsp_req = 1'b1; dsp_addr = 17'h00200; dsp_len = 10'd3;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (dsp_grant) begin
                got = 1'b1;
                stall_at_grant = cpu_stall;
                en_at_grant = mem_en;
            end else begin
                refused++;
                if (cpu_stall) stalls++;
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (got !== 1'b1 || refused != 8) begin
            errors++;
            $display("FAIL contention_refusals: granted=%b refused=%0d expected 1 8", got, refused);
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL contention_no_early_stall: got %0d stalls expected 0", stalls);
        end
        checks++;
        if ({stall_at_grant, en_at_grant} !== 2'b10) begin
            errors++;
            $display("FAIL contention_grant_cycle: stall=%b mem_en=%b expected 1 0", stall_at_grant, en_at_grant);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dsp_rvalid) rv++;
            if (dsp_done) dn++;
            if (cpu_stall) stalls++;
            tick();
        end
        checks++;
        if (rv != 3 || dn != 1 || stalls != 0) begin
            errors++;
            $display("FAIL contention_burst: rvalid=%0d done=%0d stalls=%0d expected 3 1 0", rv, dn, stalls);
        end
    endtask

    task automatic test_starvation;
        int stalls = 0;
        int rv = 0;
        int dn = 0;
        int overlap = 0;
        int gnt_n = 0;
        logic [ADDR_W-1:0] pause_addr = '0;
        logic [ADDR_W-1:0] after_addr = '0;
        logic [DATA_W-1:0] cpu_dat = '0;
        logic [DATA_W-1:0] last_dat = '0;
        logic after_next = 1'b0;
        dsp_req = 1'b1; dsp_addr = 17'h00100; dsp_len = 10'd20;
        tick();
        idle_inputs();
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00010;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (after_next) begin
                after_addr = mem_addr;
                after_next = 1'b0;
            end
            if (cpu_req && cpu_stall) stalls++;
            if (cpu_req && !cpu_stall) begin
                gnt_n++;
                pause_addr = mem_addr;
                after_next = 1'b1;
            end
            if (dsp_rvalid) begin
                rv++;
                last_dat = dsp_rdata;
            end
            if (dsp_done) dn++;
            if (cpu_rvalid) cpu_dat = cpu_rdata;
            if (cpu_rvalid && dsp_rvalid) overlap++;
            tick();
            if (after_next) cpu_req = 1'b0;
        end
        checks++;
        if (stalls != 4 || gnt_n != 1) begin
            errors++;
            $display("FAIL starve_stall: stalls=%0d grants=%0d expected 4 1", stalls, gnt_n);
        end
        checks++;
        if (pause_addr !== 17'h00010 || after_addr !== 17'h00105) begin
            errors++;
            $display("FAIL starve_pause: grant addr=%h next addr=%h expected 00010 00105", pause_addr, after_addr);
        end
        checks++;
        if (rv != 20 || dn != 1 || last_dat !== 32'hA000_0113) begin
            errors++;
            $display("FAIL starve_beats: rvalid=%0d done=%0d last=%h expected 20 1 a0000113", rv, dn, last_dat);
        end
        checks++;
        if (cpu_dat !== 32'hDEAD_BEEF || overlap != 0) begin
            errors++;
            $display("FAIL starve_cpu_read: data=%h overlap=%0d expected deadbeef 0", cpu_dat, overlap);
        end
    endtask

    task automatic test_empty_burst;
        dsp_req = 1'b1; dsp_addr = 17'h00300; dsp_len = 10'd0;
        @(negedge clk);
        checks++;
        if ({dsp_grant, mem_en, dsp_done} !== 3'b100) begin
            errors++;
            $display("FAIL empty_grant: grant/en/done=%b expected 100", {dsp_grant, mem_en, dsp_done});
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({dsp_done, dsp_rvalid, mem_en} !== 3'b100) begin
            errors++;
            $display("FAIL empty_done: done/rvalid/en=%b expected 100", {dsp_done, dsp_rvalid, mem_en});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({dsp_done, dsp_rvalid, mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL empty_after: done/rvalid/en=%b expected 000", {dsp_done, dsp_rvalid, mem_en});
        end
        tick();
    endtask

    task automatic test_reset_mid_burst;
        int rv = 0;
        int dn = 0;
        int en = 0;
        logic [DATA_W-1:0] last_dat = '0;
        dsp_req = 1'b1; dsp_addr = 17'h00400; dsp_len = 10'd10;
        tick();
        idle_inputs();
        repeat (4) tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, 17'h00404}) begin
            errors++;
            $display("FAIL rst_beat5: en=%b addr=%h expected 1 00404", mem_en, mem_addr);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_stall, cpu_rvalid, dsp_grant, dsp_rvalid, dsp_done, mem_en, mem_we, dsp_rdata, mem_addr} !== '0) begin
            errors++;
            $display("FAIL rst_outputs: ctrl=%b dsp_rdata=%h mem_addr=%h expected all 0",
                     {cpu_stall, cpu_rvalid, dsp_grant, dsp_rvalid, dsp_done, mem_en, mem_we}, dsp_rdata, mem_addr);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (dsp_rvalid) rv++;
            if (dsp_done) dn++;
            if (mem_en) en++;
            tick();
        end
        checks++;
        if (rv != 0 || dn != 0 || en != 0) begin
            errors++;
            $display("FAIL rst_quiet: rvalid=%0d done=%0d mem_en=%0d expected 0 0 0", rv, dn, en);
        end
        dsp_req = 1'b1; dsp_addr = 17'h00500; dsp_len = 10'd2;
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dsp_rvalid) begin
                rv++;
                last_dat = dsp_rdata;
            end
            if (dsp_done) dn++;
            tick();
        end
        checks++;
        if (rv != 2 || dn != 1 || last_dat !== 32'hA000_0501) begin
            errors++;
            $display("FAIL rst_new_burst: rvalid=%0d done=%0d last=%h expected 2 1 a0000501", rv, dn, last_dat);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        test_burst_wrap();
        test_contention();
        test_starvation();
        test_empty_burst();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
